dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive DMA-waiting cycles (range 1..15) before DMA wins over the CPU.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cpu_req  input  1  CPU data-memory access this cycle (load or store).
REQ-005 SHALL have port cpu_we  input  1  CPU store (qualified by cpu_req).
REQ-006 SHALL have ports cpu_addr / cpu_wdata  input  32 / 32  CPU address and store data.
REQ-007 SHALL have port cpu_rdata  output  32  load data to CPU, combinational from mem_rd.
REQ-008 SHALL have port cpu_stall  output  1  freeze CPU PC and register write this cycle.
REQ-009 SHALL have port dma_req  input  1  DMA/loader request; held with dma_we/addr/wdata stable until dma_ack.
REQ-010 SHALL have ports dma_we / dma_addr / dma_wdata  input  1 / 32 / 32  DMA command.
REQ-011 SHALL have port dma_ack  output  1  one-cycle completion pulse, registered.
REQ-012 SHALL have port dma_rdata  output  32  registered read data, valid while dma_ack=1, held after.
REQ-013 SHALL have ports mem_we / mem_addr / mem_wd  output  1 / 32 / 32  to the single-port data RAM (combinational read, synchronous write).
REQ-014 SHALL have port mem_rd  input  1x32  RAM read data.

Function
REQ-015 SHALL implement FSM {IDLE, ACK}: DMA grants only possible in IDLE; grant cycle moves IDLE->ACK; ACK->IDLE unconditionally after one cycle.
REQ-016 SHALL keep wait_cnt (4 bits): +1 each IDLE cycle with dma_req=1 and no grant, saturating at STARVE_LIMIT; cleared on grant, in ACK, and when dma_req=0.
REQ-017 SHALL compute grant_dma = (state==IDLE) & dma_req & (!cpu_req | wait_cnt>=STARVE_LIMIT), combinationally.
REQ-018 SHALL route CPU signals to mem_* when grant_dma=0 (mem_we = cpu_req & cpu_we), DMA signals when grant_dma=1 (mem_we = dma_we).
REQ-019 SHALL assert cpu_stall = cpu_req & grant_dma; no other stall source.
REQ-020 SHALL register dma_rdata <= mem_rd and dma_ack <= 1 on the grant cycle edge; dma_ack=0 otherwise.
REQ-021 SHALL treat dma_req during ACK as a new request, grantable no earlier than the following IDLE cycle (max DMA throughput one access per two cycles).
REQ-022 SHALL, with cpu_req=0 and dma_req=0, drive mem_we=0 and pass CPU address/data through.
REQ-023 SHALL give CPU priority on contention until wait_cnt reaches STARVE_LIMIT; worst-case DMA latency request->ack = STARVE_LIMIT+1 cycles.
REQ-024 SHALL never assert mem_we for both requesters or for a DMA read.

Reset
REQ-025 SHALL, while rst=0, force state=IDLE, wait_cnt=0, dma_ack=0, dma_rdata=0 immediately (asynchronous).
REQ-026 SHALL, on rst=0 mid-grant, abandon the pending ack; the DMA write of the grant cycle occurs only if a rising clk edge preceded reset.
REQ-027 SHALL resume arbitration on the first rising edge after rst returns to 1.

Configuration
REQ-028 SHALL, with macro DMEM_ARB_PERF_EN defined, add outputs stall_cnt (16) and dma_cnt (16): saturating counts of cpu_stall cycles and dma_ack pulses, reset to 0.
REQ-029 SHALL, without DMEM_ARB_PERF_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-030 SHALL cover: DMA-only write addr 0x10 data 0xDEADBEEF, cpu_req=0 -> mem_we=1 same cycle, dma_ack next cycle, CPU read of 0x10 returns 0xDEADBEEF.
REQ-031 SHALL cover: cpu_req=1 held continuously, dma_req=1 read, STARVE_LIMIT=4 -> cpu_stall=0 for 4 cycles, =1 on cycle 5, dma_ack on cycle 6.
REQ-032 SHALL cover: dma_req held high across ack, cpu_req=0 -> acks every second cycle, no back-to-back grants.
REQ-033 SHALL cover: rst=0 asserted during ACK state -> dma_ack drops at once, wait_cnt=0, dma_rdata=0.
REQ-034 SHALL cover: both requests idle -> mem_we=0, mem_addr=cpu_addr, cpu_stall=0 for 10 cycles.
REQ-035 SHALL cover, with DMEM_ARB_PERF_EN: 3 forced stalls and 5 DMA acks -> stall_cnt=3, dma_cnt=5.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU port, DMA port and data-RAM port bundle.
// slave = arbiter side; master = requesters and RAM side.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_ack;
  logic [31:0] dma_rdata;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we,
    input  cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we,
    input  dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output mem_we, mem_addr, mem_wd,
    input  mem_rd
  );

  modport master (
    output cpu_req, cpu_we,
    output cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we,
    output dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  mem_we, mem_addr, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/DMA arbiter for a single-port data RAM.
// Define DMEM_ARB_PERF_EN to add stall_cnt/dma_cnt counters.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   dma_cnt
`endif
);

  localparam logic [3:0] LIMIT =
    4'(STARVE_LIMIT);

  typedef enum logic {
    IDLE,
    ACK
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        ack_q;
  logic [31:0] rdata_q;
  logic        grant;
  logic        starved;

  assign starved = (wait_q >= LIMIT);

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant = bus.dma_req &
                (~bus.cpu_req | starved);
        if (grant) begin
          state_d = ACK;
        end else if (bus.dma_req) begin
          wait_d = starved ? wait_q
                           : wait_q + 4'd1;
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The grant cycle is the single cycle the RAM port belongs to DMA.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ack_q   <= grant;
      if (grant) begin
        rdata_q <= bus.mem_rd;
      end
    end
  end

  always_comb begin
    if (grant) begin
      bus.mem_we   = bus.dma_we;
      bus.mem_addr = bus.dma_addr;
      bus.mem_wd   = bus.dma_wdata;
    end else begin
      bus.mem_we   = bus.cpu_req & bus.cpu_we;
      bus.mem_addr = bus.cpu_addr;
      bus.mem_wd   = bus.cpu_wdata;
    end
  end

  assign bus.cpu_rdata = bus.mem_rd;
  assign bus.cpu_stall = bus.cpu_req & grant;
  assign bus.dma_ack   = ack_q;
  assign bus.dma_rdata = rdata_q;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] dma_cnt_q;
  logic        stall;

  assign stall = bus.cpu_req & grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      dma_cnt_q   <= '0;
    end else begin
      if (stall && (stall_cnt_q != 16'hffff)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (ack_q && (dma_cnt_q != 16'hffff)) begin
        dma_cnt_q <= dma_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign dma_cnt   = dma_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus random traffic
// checked against a cycle-level arbitration/memory model.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] dma_cnt;
`endif

  dmem_arbiter #(
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DMEM_ARB_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .dma_cnt(dma_cnt)
`endif
  );

  // RAM the arbiter drives: combinational read, synchronous write
  logic [31:0] ram [64];
  assign bus.mem_rd = ram[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[7:2]] <= bus.mem_wd;
  end

  // reference state
  logic [31:0] shadow [64];
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          m_busy;
  bit          m_streak;
  int          m_since;
  bit          m_ack;
  logic [31:0] m_rdata;
  int          m_stalls;
  int          m_acks;
  bit          last_grant;

  logic        o_stall;
  logic        o_ack;
  logic        o_we;
  logic [31:0] o_rdata;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_streak = 0;
    m_since = 0;
    m_ack = 0;
    m_rdata = '0;
    m_stalls = 0;
    m_acks = 0;
    last_grant = 0;
  endtask

  task automatic drive_idle();
    bus.cpu_req = 0;
    bus.cpu_we = 0;
    bus.dma_req = 0;
    bus.dma_we = 0;
  endtask

  // One clock cycle: drive, predict, compare, advance the model.
  task automatic step(input bit creq, input bit cwe,
                      input logic [31:0] caddr,
                      input logic [31:0] cwd,
                      input bit dreq, input bit dwe,
                      input logic [31:0] daddr,
                      input logic [31:0] dwd);
    bit          g;
    bit          starved;
    bit          e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [31:0] e_drd;
    @(negedge clk);
    bus.cpu_req = creq;
    bus.cpu_we = cwe;
    bus.cpu_addr = caddr;
    bus.cpu_wdata = cwd;
    bus.dma_req = dreq;
    bus.dma_we = dwe;
    bus.dma_addr = daddr;
    bus.dma_wdata = dwd;
    #1;
    // DMA wins when the port is free and either CPU is silent or
    // DMA has been refused for LIMIT consecutive cycles already.
    starved = m_streak && ((cyc - m_since) >= LIMIT);
    g = !m_busy && dreq && (!creq || starved);
    e_we = g ? dwe : (creq && cwe);
    e_addr = g ? daddr : caddr;
    e_wd = g ? dwd : cwd;
    e_drd = shadow[daddr[7:2]];
    o_stall = bus.cpu_stall;
    o_ack = bus.dma_ack;
    o_we = bus.mem_we;
    o_rdata = bus.cpu_rdata;
    chk("cpu_stall", 32'(o_stall), 32'(creq && g));
    chk("mem_we", 32'(o_we), 32'(e_we));
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_wd", bus.mem_wd, e_wd);
    chk("dma_ack", 32'(o_ack), 32'(m_ack));
    chk("dma_rdata", bus.dma_rdata, m_rdata);
    chk("cpu_rdata", o_rdata, shadow[e_addr[7:2]]);
    @(posedge clk);
    if (e_we) shadow[e_addr[7:2]] = e_wd;
    if (creq && g) m_stalls++;
    if (m_ack) m_acks++;
    if (g) m_rdata = e_drd;
    if (dreq && !m_busy && !g) begin
      if (!m_streak) begin
        m_streak = 1;
        m_since = cyc;
      end
    end else begin
      m_streak = 0;
    end
    m_ack = g;
    m_busy = g;
    last_grant = g;
    cyc++;
  endtask

  // CPU hammers the port; DMA read must win on the 5th cycle.
  task automatic starve_seq(input string tag);
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 32'h20, 32'h0, 1, 0, 32'h30, 32'h0);
      chk({tag, "_stall"}, 32'(o_stall), 32'(k == LIMIT));
      chk({tag, "_ack"}, 32'(o_ack), 32'(k == LIMIT + 1));
    end
  endtask

  bit          d_req;
  bit          d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wd;
  int          dens;

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i] = $urandom;
      shadow[i] = ram[i];
    end
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.dma_addr = '0;
    bus.dma_wdata = '0;
    drive_idle();
    model_reset();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(bus.dma_ack), 32'd0);
    chk("rst_rdata", bus.dma_rdata, 32'd0);
    chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
    rst = 1'b1;

    // both idle: CPU address passes through, no write
    for (int k = 0; k < 10; k++) begin
      step(0, $urandom_range(0, 1), $urandom, $urandom,
           0, 0, 32'h0, 32'h0);
      chk("idle_we", 32'(o_we), 32'd0);
    end

    // DMA-only write, then CPU reads it back
    step(0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'hDEADBEEF);
    chk("dmaw_we", 32'(o_we), 32'd1);
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("dmaw_ack", 32'(o_ack), 32'd1);
    step(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("dmaw_rd", o_rdata, 32'hDEADBEEF);

    starve_seq("starve");

    // DMA held high through acks: one access every two cycles
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 32'h0, 32'h0, 1, 0, 32'h44, 32'h0);
      chk("b2b_ack", 32'(o_ack), 32'(k % 2 == 1));
    end

    // reset while in ACK
    step(0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0);
    @(negedge clk);
    drive_idle();
    #1;
    chk("preack", 32'(bus.dma_ack), 32'd1);
    chk("predata", bus.dma_rdata, 32'hDEADBEEF);
    rst = 1'b0;
    #1;
    chk("rstack_ack", 32'(bus.dma_ack), 32'd0);
    chk("rstack_data", bus.dma_rdata, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // counters from reset: 3 forced stalls, 5 acks
    for (int r = 0; r < 3; r++) starve_seq("post_rst");
    for (int r = 0; r < 2; r++) begin
      step(0, 0, 32'h0, 32'h0, 1, 1, 32'h80, $urandom);
      step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    end
    #1;
`ifdef DMEM_ARB_PERF_EN
    chk("perf_stall", 32'(stall_cnt), 32'd3);
    chk("perf_dma", 32'(dma_cnt), 32'd5);
`endif

    // random traffic
    d_req = 0;
    d_we = 0;
    d_addr = '0;
    d_wd = '0;
    dens = 8;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) dens = $urandom_range(2, 10);
      if (last_grant || !d_req) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_we = $urandom_range(0, 1);
        d_addr = $urandom;
        d_wd = $urandom;
      end
      step($urandom_range(0, 9) < dens,
           $urandom_range(0, 1), $urandom, $urandom,
           d_req, d_we, d_addr, d_wd);
    end
    #1;
`ifdef DMEM_ARB_PERF_EN
    chk("perf_stall_all", 32'(stall_cnt), 32'(m_stalls));
    chk("perf_dma_all", 32'(dma_cnt), 32'(m_acks));
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
